// File: rtl/wb_regfile.sv
// Write-back stage and 31-entry register file (r0 reads as zero) with two bypassed
// read ports, a non-bypassed debug port and a committed-write counter.
module wb_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_wb_mem2reg,
  input  logic              i_wb_wreg,
  input  logic [4:0]        i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_wb_dmem,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic [4:0]        i_dbg_addr,
  output logic [DATA_W-1:0] o_id_qa,
  output logic [DATA_W-1:0] o_id_qb,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [DATA_W-1:0] o_wb_wdata,
  output logic              o_wb_we,
  output logic [31:0]       o_retire_cnt
);

  // r0 has no storage; every read path returns zero for index 0.
  logic [DATA_W-1:0] regs [1:31];

  logic rs_zero, rt_zero, dbg_zero;
  logic rs_bypass, rt_bypass;

  assign o_wb_wdata = i_wb_mem2reg ? i_wb_dmem : i_wb_data;
  assign o_wb_we    = i_wb_wreg && (i_wb_rd != 5'd0);

  assign rs_zero   = (i_id_rs == 5'd0);
  assign rt_zero   = (i_id_rt == 5'd0);
  assign dbg_zero  = (i_dbg_addr == 5'd0);
  assign rs_bypass = o_wb_we && (i_id_rs == i_wb_rd);
  assign rt_bypass = o_wb_we && (i_id_rt == i_wb_rd);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (o_wb_we) begin
      regs[i_wb_rd] <= o_wb_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_retire_cnt <= '0;
    end else if (o_wb_we) begin
      o_retire_cnt <= o_retire_cnt + 32'd1;
    end
  end

  // Bypass lets ID see the value being written this cycle instead of the stale entry.
  always_comb begin
    o_id_qa = '0;
    if (rs_zero) begin
      o_id_qa = '0;
    end else if (rs_bypass) begin
      o_id_qa = o_wb_wdata;
    end else begin
      o_id_qa = regs[i_id_rs];
    end
  end

  always_comb begin
    o_id_qb = '0;
    if (rt_zero) begin
      o_id_qb = '0;
    end else if (rt_bypass) begin
      o_id_qb = o_wb_wdata;
    end else begin
      o_id_qb = regs[i_id_rt];
    end
  end

  // Debug port shows committed state only.
  always_comb begin
    o_dbg_data = '0;
    if (!dbg_zero) begin
      o_dbg_data = regs[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: stimulus pushes expected outputs into a queue, a negedge
// monitor pops and compares them against the DUT.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem2reg, wreg;
  logic [4:0]  rd, rs, rt, dbg;
  logic [31:0] data, dmem;
  logic [31:0] qa, qb, dbg_data, wdata, retire;
  logic        we;

  wb_regfile #(.DATA_W(32)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_wb_mem2reg(mem2reg), .i_wb_wreg(wreg), .i_wb_rd(rd),
    .i_wb_data(data), .i_wb_dmem(dmem),
    .i_id_rs(rs), .i_id_rt(rt), .i_dbg_addr(dbg),
    .o_id_qa(qa), .o_id_qb(qb), .o_dbg_data(dbg_data),
    .o_wb_wdata(wdata), .o_wb_we(we), .o_retire_cnt(retire)
  );

  always #5 clk = ~clk;

  // Reference model: plain register contents and commit count.
  logic [31:0] model [32];
  logic [31:0] model_cnt;

  string       q_name [$];
  int          q_sel  [$];
  logic [31:0] q_exp  [$];

  int total = 0;
  int bad   = 0;

  function automatic void push(input string name, input int sel, input logic [31:0] exp);
    q_name.push_back(name);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
  endfunction

  function automatic logic [31:0] ref_wdata();
    return mem2reg ? dmem : data;
  endfunction

  function automatic logic ref_we();
    return wreg && (rd != 0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (ref_we() && idx == rd) return ref_wdata();
    return model[idx];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_cnt = 32'd0;
  endfunction

  function automatic void expect_all();
    push("wdata", 3, ref_wdata());
    push("we", 4, {31'd0, ref_we()});
    push("qa", 0, ref_read(rs));
    push("qb", 1, ref_read(rt));
    push("dbg", 2, (dbg == 0) ? 32'd0 : model[dbg]);
    push("retire", 5, model_cnt);
  endfunction

  task automatic apply(input logic w, input logic m, input logic [4:0] d,
                       input logic [31:0] dt, input logic [31:0] dm,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] g);
    wreg = w; mem2reg = m; rd = d; data = dt; dmem = dm; rs = a; rt = b; dbg = g;
  endtask

  // Advance one edge; the model commits what the inputs request at that edge.
  task automatic tick();
    @(posedge clk);
    if (resetn && ref_we()) begin
      model[rd] = ref_wdata();
      model_cnt = model_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin : monitor
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q_sel.size() > 0) begin
        string nm;
        int sel;
        logic [31:0] exp;
        nm = q_name.pop_front();
        sel = q_sel.pop_front();
        exp = q_exp.pop_front();
        case (sel)
          0: act = qa;
          1: act = qb;
          2: act = dbg_data;
          3: act = wdata;
          4: act = {31'd0, we};
          default: act = retire;
        endcase
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] cnt_before;
    resetn = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // All indices read zero in reset.
    for (int i = 0; i < 32; i++) begin
      apply(0, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'(i), 5'(31 - i), 5'(i));
      expect_all();
      push("rst_qa", 0, 32'd0);
      push("rst_dbg", 2, 32'd0);
      tick();
    end
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    // ALU write to r5: bypass now, committed after the edge.
    apply(1, 0, 5, 32'hDEADBEEF, 32'h12345678, 5, 5, 5);
    expect_all();
    push("byp_qa5", 0, 32'hDEADBEEF);
    push("byp_dbg5", 2, 32'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5);
    expect_all();
    push("commit_dbg5", 2, 32'hDEADBEEF);
    push("commit_cnt1", 5, 32'd1);
    tick();

    // Load then ALU write to r7 on consecutive edges.
    cnt_before = model_cnt;
    apply(1, 1, 7, 32'h0BAD0BAD, 32'h0000A5A5, 0, 7, 7);
    expect_all();
    push("load_wdata", 3, 32'h0000A5A5);
    tick();
    apply(1, 0, 7, 32'd1, 32'hFFFF0000, 7, 0, 7);
    expect_all();
    push("b2b_dbg7_first", 2, 32'h0000A5A5);
    tick();
    apply(0, 0, 0, 0, 0, 7, 7, 7);
    expect_all();
    push("b2b_dbg7_last", 2, 32'd1);
    push("b2b_cnt", 5, cnt_before + 32'd2);
    tick();

    // Write to r0 is dropped.
    cnt_before = model_cnt;
    apply(1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    expect_all();
    push("r0_we", 4, 32'd0);
    push("r0_qa", 0, 32'd0);
    push("r0_qb", 1, 32'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    expect_all();
    push("r0_cnt", 5, cnt_before);
    tick();

    // wreg low: no bypass and no commit to r9.
    apply(0, 0, 9, 32'h55, 0, 0, 9, 9);
    expect_all();
    push("nowr_qb9", 1, 32'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 9, 9);
    expect_all();
    push("nowr_dbg9", 2, 32'd0);
    tick();

    // Async reset between edges kills the pending write.
    apply(1, 0, 3, 32'h11, 0, 0, 0, 3);
    expect_all();
    tick();
    apply(1, 0, 3, 32'h22, 0, 3, 0, 3);
    #1 resetn = 1'b0;
    model_reset();
    expect_all();
    push("rst_mid_dbg3", 2, 32'd0);
    push("rst_mid_cnt", 5, 32'd0);
    push("rst_mid_qa_byp", 0, 32'h22);
    tick();
    #2 resetn = 1'b1;
    apply(0, 0, 0, 0, 0, 3, 0, 3);
    expect_all();
    push("rst_no_commit", 2, 32'd0);
    tick();
    apply(1, 0, 3, 32'h33, 0, 0, 0, 3);
    expect_all();
    tick();
    apply(0, 0, 0, 0, 0, 3, 3, 3);
    expect_all();
    push("post_rst_dbg3", 2, 32'h33);
    push("post_rst_cnt", 5, 32'd1);
    tick();

    // Randomized traffic with narrow index ranges to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd5;
      apply($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, hi)),
            $urandom, $urandom, 5'($urandom_range(0, hi)),
            5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
      if ($urandom_range(0, 59) == 0) begin
        #1 resetn = 1'b0;
        model_reset();
        expect_all();
        tick();
        #2 resetn = 1'b1;
      end else begin
        expect_all();
        tick();
      end
    end

    @(negedge clk); #1;
    total++;
    if (q_sel.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q_sel.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
